// File: rtl/wb_stage.sv
// Write-back stage. Takes retiring instructions from MEM, waits for
// multi-cycle load data, formats sub-word loads, and drives one registered
// register-file write per retired instruction. Also counts retirements.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | ready for a new instruction from MEM
// WAIT_LOAD | load accepted; waiting for mem_rvalid or the timeout limit
module wb_stage #(
  parameter int LOAD_TIMEOUT = 15,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_m,
  output logic             ready_w,
  input  logic             RegWriteM,
  input  logic [4:0]       rd_m,
  input  logic [1:0]       ResultSrcM,
  input  logic [2:0]       funct3_m,
  input  logic [31:0]      alu_result_m,
  input  logic [31:0]      PCmas4_m,
  input  logic             mem_rvalid,
  input  logic [31:0]      mem_rdata,
  output logic             reg_write_signal,
  output logic [4:0]       write_reg,
  output logic [31:0]      write_data,
  output logic             load_timeout,
  output logic [CNT_W-1:0] instret
);

  localparam int TW = $clog2(LOAD_TIMEOUT + 1);

  typedef enum logic {IDLE, WAIT_LOAD} state_t;

  state_t           state_q, state_d;
  logic [TW-1:0]    cnt_q, cnt_d;
  logic [4:0]       ld_rd_q, ld_rd_d;
  logic             ld_we_q, ld_we_d;
  logic [2:0]       ld_f3_q, ld_f3_d;
  logic [1:0]       ld_off_q, ld_off_d;
  logic             rws_q, rws_d;
  logic [4:0]       wreg_q, wreg_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             lto_q, lto_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;
  logic [31:0]      load_data;

  assign ready_w          = (state_q == IDLE);
  assign reg_write_signal = rws_q;
  assign write_reg        = wreg_q;
  assign write_data       = wdata_q;
  assign load_timeout     = lto_q;
  assign instret          = instret_q;

  // Sub-word load extraction and sign/zero extension from the latched size/offset.
  always_comb begin
    byte_sel  = mem_rdata[{ld_off_q, 3'b000} +: 8];
    half_sel  = ld_off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    load_data = mem_rdata;
    case (ld_f3_q)
      3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_data = {24'd0, byte_sel};
      3'b101:  load_data = {16'd0, half_sel};
      default: load_data = mem_rdata;
    endcase
  end

  // Next-state and next-output logic; write pulse defaults low, data/reg hold.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ld_rd_d   = ld_rd_q;
    ld_we_d   = ld_we_q;
    ld_f3_d   = ld_f3_q;
    ld_off_d  = ld_off_q;
    rws_d     = 1'b0;
    wreg_d    = wreg_q;
    wdata_d   = wdata_q;
    lto_d     = lto_q;
    instret_d = instret_q;
    case (state_q)
      IDLE: begin
        if (valid_m) begin
          if (ResultSrcM == 2'b01) begin
            ld_rd_d  = rd_m;
            ld_we_d  = RegWriteM;
            ld_f3_d  = funct3_m;
            ld_off_d = alu_result_m[1:0];
            cnt_d    = '0;
            state_d  = WAIT_LOAD;
          end else begin
            rws_d     = RegWriteM & (rd_m != 5'd0);
            wreg_d    = rd_m;
            wdata_d   = (ResultSrcM == 2'b10) ? PCmas4_m : alu_result_m;
            instret_d = instret_q + 1'b1;
          end
        end
      end
      WAIT_LOAD: begin
        if (mem_rvalid) begin
          // Data arriving on the limit cycle still completes the load.
          rws_d     = ld_we_q & (ld_rd_q != 5'd0);
          wreg_d    = ld_rd_q;
          wdata_d   = load_data;
          instret_d = instret_q + 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == TW'(LOAD_TIMEOUT - 1)) begin
            lto_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset discards any pending load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ld_rd_q   <= '0;
      ld_we_q   <= 1'b0;
      ld_f3_q   <= '0;
      ld_off_q  <= '0;
      rws_q     <= 1'b0;
      wreg_q    <= '0;
      wdata_q   <= '0;
      lto_q     <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ld_rd_q   <= ld_rd_d;
      ld_we_q   <= ld_we_d;
      ld_f3_q   <= ld_f3_d;
      ld_off_q  <= ld_off_d;
      rws_q     <= rws_d;
      wreg_q    <= wreg_d;
      wdata_q   <= wdata_d;
      lto_q     <= lto_d;
      instret_q <= instret_d;
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: table of retiring instructions applied back to back,
// expected writes queued at issue and checked whenever instret advances,
// plus hand sequences for timeout, early rvalid and reset mid-load.
module tb_wb_stage;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             valid_m = 1'b0;
  logic             ready_w;
  logic             RegWriteM = 1'b0;
  logic [4:0]       rd_m = '0;
  logic [1:0]       ResultSrcM = '0;
  logic [2:0]       funct3_m = '0;
  logic [31:0]      alu_result_m = '0;
  logic [31:0]      PCmas4_m = '0;
  logic             mem_rvalid = 1'b0;
  logic [31:0]      mem_rdata = '0;
  logic             reg_write_signal;
  logic [4:0]       write_reg;
  logic [31:0]      write_data;
  logic             load_timeout;
  logic [CNT_W-1:0] instret;

  wb_stage #(.LOAD_TIMEOUT(15), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .valid_m(valid_m), .ready_w(ready_w),
    .RegWriteM(RegWriteM), .rd_m(rd_m), .ResultSrcM(ResultSrcM),
    .funct3_m(funct3_m), .alu_result_m(alu_result_m), .PCmas4_m(PCmas4_m),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .reg_write_signal(reg_write_signal), .write_reg(write_reg),
    .write_data(write_data), .load_timeout(load_timeout), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rw;
    logic [4:0]  rd;
    logic [1:0]  src;
    logic [2:0]  f3;
    logic [31:0] alu;
    logic [31:0] pc4;
    logic [31:0] rdata;
    int          dly;
    logic        exp_we;
    logic [31:0] exp_data;
  } vec_t;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  vec_t vecs[20];
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   run = 0;
  int   max_run = 0;
  logic [CNT_W-1:0] prev_instret = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Retirement monitor: every instret step pops one expected write.
  always @(negedge clk) begin
    if (!reset) begin
      prev_instret = '0;
      run = 0;
    end else begin
      run = reg_write_signal ? run + 1 : 0;
      if (run > max_run) max_run = run;
      if (instret != prev_instret) begin
        chk("instret_step", 32'(instret), 32'(CNT_W'(prev_instret + 1'b1)));
        prev_instret = instret;
        if (exp_q.size() == 0) begin
          chk("unexpected_retire", 32'(1), 32'(0));
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("wr_en", 32'(reg_write_signal), 32'(e.we));
          chk("wr_reg", 32'(write_reg), 32'(e.rd));
          chk("wr_data", write_data, e.data);
        end
      end else if (reg_write_signal) begin
        chk("pulse_without_retire", 32'(1), 32'(0));
      end
    end
  end

  task automatic wait_ready();
    int t = 0;
    while (!ready_w && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (!ready_w) chk("ready_timeout", 32'(ready_w), 32'(1));
  endtask

  task automatic do_txn(input vec_t v);
    exp_t e;
    wait_ready();
    valid_m = 1'b1; RegWriteM = v.rw; rd_m = v.rd; ResultSrcM = v.src;
    funct3_m = v.f3; alu_result_m = v.alu; PCmas4_m = v.pc4;
    e.we = v.exp_we; e.rd = v.rd; e.data = v.exp_data;
    exp_q.push_back(e);
    @(posedge clk); #1;
    valid_m = 1'b0;
    if (v.src == 2'b01) begin
      for (int k = 1; k < v.dly; k++) begin
        chk("ready_low_wait", 32'(ready_w), 32'(0));
        @(posedge clk); #1;
      end
      mem_rvalid = 1'b1; mem_rdata = v.rdata;
      chk("ready_low_rvalid", 32'(ready_w), 32'(0));
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
      chk("ready_after_load", 32'(ready_w), 32'(1));
    end
  endtask

  initial begin
    vecs[0]  = '{1'b1, 5'd5,  2'b00, 3'b000, 32'h0000_1234, 32'h0,     32'h0,          0, 1'b1, 32'h0000_1234};
    vecs[1]  = '{1'b1, 5'd7,  2'b11, 3'b000, 32'hDEAD_BEEF, 32'h0,     32'h0,          0, 1'b1, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b1, 5'd0,  2'b10, 3'b000, 32'h0,         32'h40,    32'h0,          0, 1'b0, 32'h0000_0040};
    vecs[3]  = '{1'b1, 5'd1,  2'b10, 3'b000, 32'h999,       32'h104,   32'h0,          0, 1'b1, 32'h0000_0104};
    vecs[4]  = '{1'b0, 5'd9,  2'b00, 3'b000, 32'h55,        32'h0,     32'h0,          0, 1'b0, 32'h0000_0055};
    vecs[5]  = '{1'b1, 5'd10, 2'b01, 3'b000, 32'h1003,      32'h0,     32'h80FF_0000,  3, 1'b1, 32'hFFFF_FF80};
    vecs[6]  = '{1'b1, 5'd11, 2'b01, 3'b101, 32'h2,         32'h0,     32'h8001_0000,  1, 1'b1, 32'h0000_8001};
    vecs[7]  = '{1'b1, 5'd12, 2'b01, 3'b001, 32'h6,         32'h0,     32'h8001_0000,  2, 1'b1, 32'hFFFF_8001};
    vecs[8]  = '{1'b1, 5'd13, 2'b01, 3'b100, 32'h1,         32'h0,     32'h1234_F600,  1, 1'b1, 32'h0000_00F6};
    vecs[9]  = '{1'b1, 5'd14, 2'b01, 3'b000, 32'h0,         32'h0,     32'h0000_007F,  1, 1'b1, 32'h0000_007F};
    vecs[10] = '{1'b1, 5'd15, 2'b01, 3'b010, 32'h3,         32'h0,     32'hCAFE_BABE,  1, 1'b1, 32'hCAFE_BABE};
    vecs[11] = '{1'b1, 5'd16, 2'b01, 3'b111, 32'h1,         32'h0,     32'h0102_0304,  2, 1'b1, 32'h0102_0304};
    vecs[12] = '{1'b1, 5'd17, 2'b01, 3'b001, 32'h0,         32'h0,     32'h1234_ABCD,  1, 1'b1, 32'hFFFF_ABCD};
    vecs[13] = '{1'b1, 5'd0,  2'b01, 3'b010, 32'h0,         32'h0,     32'hA5A5_A5A5,  1, 1'b0, 32'hA5A5_A5A5};
    vecs[14] = '{1'b0, 5'd3,  2'b01, 3'b000, 32'h2,         32'h0,     32'h0080_0000,  1, 1'b0, 32'hFFFF_FF80};
    vecs[15] = '{1'b1, 5'd4,  2'b01, 3'b010, 32'h0,         32'h0,     32'h1111_1111, 15, 1'b1, 32'h1111_1111};
    for (int i = 0; i < 4; i++)
      vecs[16+i] = '{1'b1, 5'(20 + i), 2'b00, 3'b000, 32'(32'h100 + i), 32'h0, 32'h0, 0, 1'b1, 32'(32'h100 + i)};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_we", 32'(reg_write_signal), 32'(0));
    chk("rst_reg", 32'(write_reg), 32'(0));
    chk("rst_data", write_data, 32'(0));
    chk("rst_lto", 32'(load_timeout), 32'(0));
    chk("rst_instret", 32'(instret), 32'(0));
    chk("rst_ready", 32'(ready_w), 32'(1));
    reset = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) do_txn(vecs[i]);
    repeat (3) @(posedge clk);
    #1;
    chk("b2b_run_ge4", 32'(max_run >= 4), 32'(1));
    chk("lto_after_limit_rvalid", 32'(load_timeout), 32'(0));
    chk("instret_after_table", 32'(instret), 32'(CNT_W'(20)));

    // Timeout: load accepted, rvalid never arrives.
    valid_m = 1'b1; RegWriteM = 1'b1; rd_m = 5'd8; ResultSrcM = 2'b01;
    funct3_m = 3'b010; alu_result_m = 32'h0;
    @(posedge clk); #1;
    valid_m = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      chk("to_ready_low", 32'(ready_w), 32'(0));
      @(posedge clk); #1;
    end
    chk("to_ready_high", 32'(ready_w), 32'(1));
    chk("to_flag", 32'(load_timeout), 32'(1));
    chk("to_instret", 32'(instret), 32'(CNT_W'(20)));
    repeat (2) @(posedge clk);
    #1;
    chk("to_flag_sticky", 32'(load_timeout), 32'(1));

    // rvalid during the acceptance cycle must be ignored.
    begin
      exp_t e;
      e.we = 1'b1; e.rd = 5'd6; e.data = 32'h0000_0022;
      exp_q.push_back(e);
    end
    valid_m = 1'b1; RegWriteM = 1'b1; rd_m = 5'd6; ResultSrcM = 2'b01;
    funct3_m = 3'b100; alu_result_m = 32'h2;
    mem_rvalid = 1'b1; mem_rdata = 32'h0099_0000;
    @(posedge clk); #1;
    valid_m = 1'b0; mem_rvalid = 1'b0;
    chk("early_rv_ready", 32'(ready_w), 32'(0));
    @(posedge clk); #1;
    mem_rvalid = 1'b1; mem_rdata = 32'h0022_0000;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("instret_wrapped", 32'(instret), 32'(CNT_W'(21)));

    // Reset while waiting for load data: pending load is dropped.
    valid_m = 1'b1; RegWriteM = 1'b1; rd_m = 5'd9; ResultSrcM = 2'b01;
    funct3_m = 3'b010; alu_result_m = 32'h0;
    @(posedge clk); #1;
    valid_m = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    #2;
    mem_rvalid = 1'b1; mem_rdata = 32'h7777_7777;
    chk("mid_rst_ready", 32'(ready_w), 32'(1));
    chk("mid_rst_data", write_data, 32'(0));
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst_we", 32'(reg_write_signal), 32'(0));
    chk("post_rst_reg", 32'(write_reg), 32'(0));
    chk("post_rst_data", write_data, 32'(0));
    chk("post_rst_lto", 32'(load_timeout), 32'(0));
    chk("post_rst_instret", 32'(instret), 32'(0));
    chk("post_rst_ready", 32'(ready_w), 32'(1));
    chk("queue_empty", 32'(exp_q.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
